// File: rtl/dpd_phase_err_pkg.sv
// dpd_pkg: shared definitions for the multi-bit phase detector.
//   - dpd_state_e : measurement FSM states (IDLE, REF_FIRST, CTRL_FIRST)
//   - err_max()   : saturation magnitude of the error counter for a given CNT_W
//   - ERR_POS/NEG : sign of the emitted error (positive = ctrl edge late)
package dpd_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REF_FIRST  = 2'd1,
        CTRL_FIRST = 2'd2
    } dpd_state_e;

    // ref edge first -> ctrl is late -> positive error
    localparam logic ERR_POS = 1'b0;
    localparam logic ERR_NEG = 1'b1;

    // Largest magnitude representable in the CNT_W-bit signed error.
    function automatic int err_max(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/dpd_phase_err_if.sv
// dpd_phase_err_if: measurement results from the phase detector to the loop filter.
//   ref_rise     - pulse on synchronised ref rising edge
//   phase_err    - signed error, qualified by err_valid
//   lead / lag   - dead-zone-filtered direction pulses
//   ref_period   - last ref period, qualified by period_valid
//   locked       - lock indicator (tied low unless lock detect is built in)
// modport master: detector side (drives); modport slave: consumer side.
interface dpd_phase_err_if #(
    parameter int CNT_W = 10
);
    logic                    ref_rise;
    logic signed [CNT_W-1:0] phase_err;
    logic                    err_valid;
    logic                    lead;
    logic                    lag;
    logic [CNT_W-1:0]        ref_period;
    logic                    period_valid;
    logic                    locked;

    modport master (
        output ref_rise, phase_err, err_valid, lead, lag,
               ref_period, period_valid, locked
    );

    modport slave (
        input  ref_rise, phase_err, err_valid, lead, lag,
               ref_period, period_valid, locked
    );
endinterface

// File: rtl/dpd_phase_err_edge_sync.sv
// dpd_edge_sync: SYNC_STAGES-flop synchroniser followed by one delay flop.
//   clk, rst - system clock, synchronous active-high reset
//   din      - asynchronous input
//   rise     - combinational pulse: synchronised input high, delayed copy low
// Both detector inputs use this block so their latency is identical.
module dpd_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;
endmodule

// File: rtl/dpd_phase_err.sv
// dpd_phase_err: multi-bit phase detector between ref_signal and ctrl_signal.
//   clk, rst      - system clock, synchronous active-high reset
//   ref_signal    - reference clock (async to clk)
//   ctrl_signal   - DCO feedback clock (async to clk)
//   bus (master)  - ref_rise, phase_err/err_valid, lead/lag, ref_period/
//                   period_valid, locked
// Optional lock detector built when DPD_LOCK_DETECT_EN is defined; otherwise
// locked is tied low.
module dpd_phase_err
    import dpd_pkg::*;
#(
    parameter int CNT_W       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int DEAD_ZONE   = 0,
    parameter int LOCK_CNT    = 8,
    parameter int LOCK_TOL    = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ref_signal,
    input  logic           ctrl_signal,
    dpd_phase_err_if.master bus
);
    localparam int                      MAG_W = CNT_W - 1;
    localparam logic [MAG_W-1:0]        MAX   = MAG_W'(err_max(CNT_W));
    localparam logic signed [CNT_W-1:0] DZ    = CNT_W'(DEAD_ZONE);

    logic r_rise, c_rise;

    dpd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ref_signal),
        .rise (r_rise)
    );

    dpd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ctrl_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ctrl_signal),
        .rise (c_rise)
    );

    // ---------------- measurement FSM ----------------
    dpd_state_e       state, state_nxt;
    logic [MAG_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             emit_vld, emit_neg;
    logic [MAG_W-1:0] emit_mag;

    // cnt holds (cycles since first edge - 1); the incremented value is the
    // detect-cycle distance, which is what gets emitted.
    assign cnt_inc = (cnt == MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        emit_vld  = 1'b0;
        emit_neg  = ERR_POS;
        emit_mag  = '0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (r_rise && c_rise) begin
                    emit_vld = 1'b1;
                end else if (r_rise) begin
                    state_nxt = REF_FIRST;
                end else if (c_rise) begin
                    state_nxt = CTRL_FIRST;
                end
            end
            REF_FIRST: begin
                if (c_rise) begin
                    emit_vld = 1'b1;
                    emit_mag = cnt_inc;
                    if (r_rise) cnt_nxt   = '0;   // new ref edge opens next window
                    else        state_nxt = IDLE;
                end else if (r_rise) begin
                    // ctrl edge missed for a whole ref period
                    emit_vld = 1'b1;
                    emit_mag = MAX;
                    cnt_nxt  = '0;
                end
            end
            CTRL_FIRST: begin
                emit_neg = ERR_NEG;
                if (r_rise) begin
                    emit_vld = 1'b1;
                    emit_mag = cnt_inc;
                    if (c_rise) cnt_nxt   = '0;
                    else        state_nxt = IDLE;
                end else if (c_rise) begin
                    emit_vld = 1'b1;
                    emit_mag = MAX;
                    cnt_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------- registered error output ----------------
    logic signed [CNT_W-1:0] emit_val, phase_err_q;
    logic                    err_valid_q;

    assign emit_val = (emit_neg == ERR_NEG) ? -$signed({1'b0, emit_mag})
                                            :  $signed({1'b0, emit_mag});

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_err_q <= '0;
            err_valid_q <= 1'b0;
        end else begin
            err_valid_q <= emit_vld;
            if (emit_vld) phase_err_q <= emit_val;
        end
    end

    // ---------------- reference period ----------------
    logic [CNT_W-1:0] pcnt, pcnt_inc, ref_period_q;
    logic             armed, period_valid_q;

    assign pcnt_inc = (&pcnt) ? pcnt : pcnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt           <= '0;
            armed          <= 1'b0;
            ref_period_q   <= '0;
            period_valid_q <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            if (r_rise) begin
                pcnt  <= '0;
                armed <= 1'b1;
                // first edge after reset only starts the count
                if (armed) begin
                    ref_period_q   <= pcnt_inc;
                    period_valid_q <= 1'b1;
                end
            end else begin
                pcnt <= pcnt_inc;
            end
        end
    end

    // ---------------- lock detect ----------------
`ifdef DPD_LOCK_DETECT_EN
    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    logic [RUN_W-1:0] run;
    logic [CNT_W-1:0] err_abs;
    logic             in_tol;

    assign err_abs = phase_err_q[CNT_W-1] ? CNT_W'(-phase_err_q) : CNT_W'(phase_err_q);
    assign in_tol  = (err_abs <= CNT_W'(LOCK_TOL));

    always_ff @(posedge clk) begin
        if (rst) begin
            run <= '0;
        end else if (err_valid_q) begin
            if (!in_tol)                       run <= '0;
            else if (run != RUN_W'(LOCK_CNT))  run <= run + 1'b1;
        end
    end

    assign bus.locked = (run == RUN_W'(LOCK_CNT));
`else
    // Lock parameters are still referenced so both builds share one interface.
    assign bus.locked = 1'b0 & (LOCK_CNT > 0) & (LOCK_TOL >= 0);
`endif

    // ---------------- outputs ----------------
    assign bus.ref_rise     = r_rise;
    assign bus.phase_err    = phase_err_q;
    assign bus.err_valid    = err_valid_q;
    assign bus.lag          = err_valid_q && (phase_err_q > DZ);
    assign bus.lead         = err_valid_q && (phase_err_q < -DZ);
    assign bus.ref_period   = ref_period_q;
    assign bus.period_valid = period_valid_q;
endmodule
